// File: rtl/ndf_target_if.sv
// Host-side NAND bus between a sequencer (master) and the flash target (slave).
// Strobes are active-low levels sampled on clk10; data is latched on the rising edge of ndf_we_n.
interface ndf_target_if;
   logic       ndf_ce_n;
   logic       ndf_cle;
   logic       ndf_ale;
   logic       ndf_we_n;
   logic       ndf_re_n;
   logic       ndf_wp_n;
   logic [7:0] ndf_io_i;
   logic [7:0] ndf_io_o;
   logic       ndf_io_oe;
   logic       ndf_r_b_n;

   modport master (
      output ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n, ndf_wp_n, ndf_io_i,
      input  ndf_io_o, ndf_io_oe, ndf_r_b_n
   );

   modport slave (
      input  ndf_ce_n, ndf_cle, ndf_ale, ndf_we_n, ndf_re_n, ndf_wp_n, ndf_io_i,
      output ndf_io_o, ndf_io_oe, ndf_r_b_n
   );
endinterface

// File: rtl/ndf_target.sv
// NAND flash target responder: decodes FFh/90h/00h-30h/70h from the host bus and
// answers with ID bytes, a col^row page pattern and the status byte.
module ndf_target #(
   parameter int         RESET_BUSY = 16,
   parameter int         READ_BUSY  = 32,
   parameter int         PAGE_BYTES = 2048,
   parameter logic [7:0] ID0        = 8'hEC,
   parameter logic [7:0] ID1        = 8'hD3,
   parameter logic [7:0] ID2        = 8'h51,
   parameter logic [7:0] ID3        = 8'h95,
   parameter logic [7:0] ID4        = 8'h58
) (
   input  logic            clk10,
   input  logic            rst_n,
   ndf_target_if.slave     bus,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      BUSY       = 3'd0,
      IDLE       = 3'd1,
      ID_ADDR    = 3'd2,
      ID_OUT     = 3'd3,
      RD_ADDR    = 3'd4,
      RD_WAIT    = 3'd5,
      DATA_OUT   = 3'd6,
      STATUS_OUT = 3'd7
   } state_t;

   localparam logic [11:0] COL_MASK = 12'(PAGE_BYTES - 1);

   state_t      state;
   logic        s_we, s_re, s_cle, s_ale;
   logic [7:0]  s_io;
   logic        lat_cle, lat_ale;
   logic [7:0]  lat_io;
   logic [15:0] busy_cnt;
   logic [2:0]  id_idx;
   logic [2:0]  addr_cnt;
   logic [11:0] col;
   logic [7:0]  row_lo;
   logic        ret_data;
   logic        stat_busy;
   logic        prev_data;
   logic        r_b_n_q;

   logic        we_evt, rd_adv, is_cmd, is_addr;
   logic        drive;
   logic [7:0]  out_byte;

   assign we_evt  = !s_we && bus.ndf_we_n && !bus.ndf_ce_n;
   // A write event in the same cycle swallows a read advance.
   assign rd_adv  = !s_re && bus.ndf_re_n && !bus.ndf_ce_n && !we_evt;
   assign is_cmd  = lat_cle && !lat_ale;
   assign is_addr = lat_ale && !lat_cle;

   function automatic logic [7:0] id_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    id_byte = ID0;
         3'd1:    id_byte = ID1;
         3'd2:    id_byte = ID2;
         3'd3:    id_byte = ID3;
         default: id_byte = ID4;
      endcase
   endfunction

   always_ff @(posedge clk10 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= BUSY;
         s_we      <= 1'b1;
         s_re      <= 1'b1;
         s_cle     <= 1'b0;
         s_ale     <= 1'b0;
         s_io      <= 8'h00;
         lat_cle   <= 1'b0;
         lat_ale   <= 1'b0;
         lat_io    <= 8'h00;
         busy_cnt  <= 16'(RESET_BUSY);
         id_idx    <= 3'd0;
         addr_cnt  <= 3'd0;
         col       <= 12'd0;
         row_lo    <= 8'h00;
         ret_data  <= 1'b0;
         stat_busy <= 1'b0;
         prev_data <= 1'b0;
         r_b_n_q   <= 1'b0;
      end else begin
         s_we  <= bus.ndf_we_n;
         s_re  <= bus.ndf_re_n;
         s_cle <= bus.ndf_cle;
         s_ale <= bus.ndf_ale;
         s_io  <= bus.ndf_io_i;
         if (!s_we) begin
            lat_cle <= s_cle;
            lat_ale <= s_ale;
            lat_io  <= s_io;
         end

         if (state == BUSY) begin
            if (we_evt && is_cmd && lat_io == 8'hFF) begin
               busy_cnt  <= 16'(RESET_BUSY);
               ret_data  <= 1'b0;
               stat_busy <= 1'b0;
            end else begin
               if (we_evt && is_cmd && lat_io == 8'h70)
                  stat_busy <= 1'b1;
               busy_cnt <= busy_cnt - 16'd1;
               if (busy_cnt <= 16'd1) begin
                  r_b_n_q   <= 1'b1;
                  ret_data  <= 1'b0;
                  stat_busy <= 1'b0;
                  // A status read issued while busy keeps the host in status mode afterwards.
                  if (stat_busy || (we_evt && is_cmd && lat_io == 8'h70)) begin
                     state     <= STATUS_OUT;
                     prev_data <= ret_data;
                  end else begin
                     state <= ret_data ? DATA_OUT : IDLE;
                  end
               end
            end
         end else if (we_evt && is_cmd) begin
            case (lat_io)
               8'hFF: begin
                  state     <= BUSY;
                  busy_cnt  <= 16'(RESET_BUSY);
                  r_b_n_q   <= 1'b0;
                  ret_data  <= 1'b0;
                  stat_busy <= 1'b0;
               end
               8'h90: state <= ID_ADDR;
               8'h00: begin
                  if (state == STATUS_OUT && prev_data) begin
                     state <= DATA_OUT;
                  end else begin
                     col      <= 12'd0;
                     row_lo   <= 8'h00;
                     addr_cnt <= 3'd0;
                     state    <= RD_ADDR;
                  end
               end
               8'h70: begin
                  prev_data <= (state == DATA_OUT) || (state == STATUS_OUT && prev_data);
                  state     <= STATUS_OUT;
               end
               8'h30: begin
                  if (state == RD_WAIT) begin
                     state    <= BUSY;
                     busy_cnt <= 16'(READ_BUSY);
                     r_b_n_q  <= 1'b0;
                     ret_data <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (we_evt && is_addr) begin
            case (state)
               ID_ADDR: begin
                  id_idx <= 3'd0;
                  state  <= ID_OUT;
               end
               RD_ADDR: begin
                  // Only col and the low row byte shape the page pattern; upper row bytes are counted only.
                  case (addr_cnt)
                     3'd0:    col[7:0]  <= lat_io;
                     3'd1:    col[11:8] <= lat_io[3:0];
                     3'd2:    row_lo    <= lat_io;
                     default: ;
                  endcase
                  addr_cnt <= addr_cnt + 3'd1;
                  if (addr_cnt == 3'd4)
                     state <= RD_WAIT;
               end
               default: ;
            endcase
         end else if (rd_adv) begin
            if (state == ID_OUT)
               id_idx <= (id_idx == 3'd4) ? 3'd0 : id_idx + 3'd1;
            else if (state == DATA_OUT)
               col <= (col + 12'd1) & COL_MASK;
         end
      end
   end

   always_comb begin
      drive    = 1'b0;
      out_byte = 8'h00;
      case (state)
         ID_OUT: begin
            drive    = 1'b1;
            out_byte = id_byte(id_idx);
         end
         DATA_OUT: begin
            drive    = 1'b1;
            out_byte = col[7:0] ^ row_lo;
         end
         STATUS_OUT: begin
            drive    = 1'b1;
            out_byte = {bus.ndf_wp_n, 1'b1, 6'b0};
         end
         BUSY: begin
            drive    = stat_busy;
            out_byte = {bus.ndf_wp_n, 1'b0, 6'b0};
         end
         default: ;
      endcase
   end

   assign bus.ndf_io_oe = drive && !bus.ndf_ce_n && !bus.ndf_re_n;
   assign bus.ndf_io_o  = bus.ndf_io_oe ? out_byte : 8'h00;
   assign bus.ndf_r_b_n = r_b_n_q;
   assign dbg_state     = state;

endmodule
